adc_channel_averager: RTL and testbench
=======================================

Name: adc_channel_averager

Overview:
- Downstream consumer of the modular ADC response stream (valid/channel/data, no backpressure).
- Boxcar-averages 2^LOG2_AVG consecutive samples independently per channel.
- Emits one averaged 12-bit result per completed window on an Avalon-ST source with ready/valid backpressure.
- Results are buffered in a small show-ahead FIFO; overflow is flagged sticky.

Parameters:
- NUM_CH, 8: number of channels averaged (channel numbers 0..NUM_CH-1), 1..32.
- LOG2_AVG, 4: window length is 2^LOG2_AVG samples, 0..8.
- OFIFO_DEPTH, 4: result FIFO depth; power of two, >=2.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- enable  in  1  1 = accept samples; 0 = ignore in_valid, accumulators hold
- clear  in  1  synchronous clear: zero all accumulators/counts, flush FIFO, clear overflow
- in_valid  in  1  sample strobe from ADC response
- in_channel  in  5  sample channel
- in_data  in  12  sample value, unsigned
- in_startofpacket  in  1  accepted, unused
- in_endofpacket  in  1  accepted, unused
- out_valid  out  1  FIFO head valid
- out_ready  in  1  sink ready; transfer when out_valid & out_ready
- out_channel  out  5  channel of head result
- out_data  out  12  averaged value of head result
- overflow  out  1  sticky: a completed result was dropped

Behaviour:
- Reset (async assert, sync release):
  - all accumulators and counts are 0; FIFO empty.
  - out_valid=0, out_channel=0, out_data=0, overflow=0.
- Per channel state: acc[ch] is 12+LOG2_AVG bits; cnt[ch] is LOG2_AVG bits. Accumulator cannot wrap: max sum 0xFFF*2^N fits.
- Sample accepted when in_valid & enable & !clear & in_channel<NUM_CH.
  - Channels >= NUM_CH are silently discarded; no state change.
- Accepted sample, normal case: sum = acc[ch]+in_data.
  - If cnt[ch] != 2^N-1: acc[ch]<=sum, cnt[ch]<=cnt[ch]+1.
- Window completion (cnt[ch]==2^N-1):
  - Push {ch, sum>>LOG2_AVG} (truncating) into the FIFO.
  - acc[ch]<=0, cnt[ch]<=0, whether or not the push succeeds.
- LOG2_AVG=0: every accepted sample completes a window (pass-through with 1-cycle latency).
- Latency: a sample in cycle t that completes a window gives out_valid=1 in cycle t+1 when the FIFO was empty.
- FIFO is show-ahead: out_channel/out_data reflect the head whenever out_valid=1. They hold their last value when empty (0 after reset).
- Pop on out_valid & out_ready. Data and ordering are preserved; results appear in completion order across channels.
- Full-FIFO push:
  - If a pop occurs in the same cycle, the push is accepted (count unchanged).
  - Otherwise the result is dropped and overflow<=1.
- overflow clears only on clear or reset.
- Push into an empty FIFO with out_ready=1 in the same cycle: the result is not visible until t+1; it pops no earlier than t+1.
- clear:
  - Takes effect at the next edge and wins over any simultaneous sample/push/pop.
  - The sample in that cycle is discarded.
  - out_valid=0 in the following cycle.
- enable=0 mid-window: partial sums and counts retained; accumulation resumes on re-enable.
- Reset mid-window: everything discarded; no partial result emitted.
- One sample per cycle max; back-to-back in_valid on the same channel must accumulate correctly (no read-after-write hazard).

Test Plan:
- LOG2_AVG=4, out_ready=1: 16 samples ch1 data=100 (0x064) -> exactly one beat ch=1 data=0x064, one cycle after the 16th sample.
- Interleave ch0 (0xFFF x16) and ch3 (alternating 0x000/0x001 x16) -> ch0 beat data=0xFFF (no wrap), ch3 beat data=0x000 (8/16 truncated). Order matches completion order.
- out_ready=0, complete 5 windows on ch2 with OFIFO_DEPTH=4 -> out_valid=1, overflow=1 after 5th. Then raise out_ready -> exactly 4 beats, then out_valid=0.
- in_channel=9 samples x32 with NUM_CH=8 -> no output, no overflow. Then 16 samples on ch7 -> one beat ch=7.
- 10 samples ch4, then clear pulse (with a simultaneous ch4 sample), then 16 samples of 50 -> one beat data=50; overflow=0.
- 10 samples ch5, assert reset_reset_n=0 asynchronously mid-cycle -> outputs 0 immediately. After release, 16 samples of 7 -> single beat data=7.

Source files
------------

// File: rtl/adc_channel_averager.sv
// Per-channel boxcar averager over 2^LOG2_AVG ADC samples; one result per completed window, 1-cycle latency into an empty FIFO.
// Results queue in a show-ahead FIFO with out_valid/out_ready backpressure; a push into a full FIFO without a pop is dropped and sets overflow.

module adc_avg_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [W-1:0]  last_dat;
  logic          push, pop;

  assign rd_vld = (count != '0);
  assign pop    = rd_vld & rd_rdy;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_rdy = (count != (PW+1)'(DEPTH)) | pop;
  assign push   = wr_vld & wr_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : last_dat;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_dat <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        last_dat <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module adc_channel_averager #(
  parameter int NUM_CH      = 8,
  parameter int LOG2_AVG    = 4,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [4:0]  in_channel,
  input  logic [11:0] in_data,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_channel,
  output logic [11:0] out_data,
  output logic        overflow
);
  localparam int AW  = 12 + LOG2_AVG;
  localparam int CW  = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

  logic [AW-1:0]  acc [NUM_CH];
  logic [CW-1:0]  cnt [NUM_CH];
  logic [CHW-1:0] ch_idx;
  logic           in_range, accept, win_done;
  logic [AW-1:0]  sum;
  logic [11:0]    avg;
  logic           push_vld, push_rdy;
  logic [16:0]    push_dat, head_dat;
  logic           unused_ok;

  assign unused_ok = in_startofpacket ^ in_endofpacket;

  assign ch_idx   = in_channel[CHW-1:0];
  assign in_range = ({1'b0, in_channel} < 6'(NUM_CH));
  assign accept   = in_valid & enable & ~clear & in_range;
  // With LOG2_AVG=0 the count stays 0 and every sample ends its window.
  assign win_done = (cnt[ch_idx] == CNT_LAST);
  assign sum      = acc[ch_idx] + AW'(in_data);
  assign avg      = 12'(sum >> LOG2_AVG);
  assign push_vld = accept & win_done;
  assign push_dat = {in_channel, avg};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (accept) begin
      // The window restarts even if the FIFO drops the result.
      if (win_done) begin
        acc[ch_idx] <= '0;
        cnt[ch_idx] <= '0;
      end else begin
        acc[ch_idx] <= sum;
        cnt[ch_idx] <= cnt[ch_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)            overflow <= 1'b0;
    else if (clear)                overflow <= 1'b0;
    else if (push_vld && !push_rdy) overflow <= 1'b1;
  end

  adc_avg_fifo #(
    .W     (17),
    .DEPTH (OFIFO_DEPTH)
  ) u_ofifo (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .flush  (clear),
    .wr_vld (push_vld),
    .wr_rdy (push_rdy),
    .wr_dat (push_dat),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (head_dat)
  );

  assign out_channel = head_dat[16:12];
  assign out_data    = head_dat[11:0];
endmodule

// File: tb/tb_adc_channel_averager.sv
// Randomized and directed bench for adc_channel_averager against a window-sum/queue reference model.
module tb_adc_channel_averager;
  localparam int NUM_CH = 8;
  localparam int L      = 4;
  localparam int DEPTH  = 4;
  localparam int WIN    = 1 << L;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        enable = 1'b0, clear = 1'b0, in_valid = 1'b0;
  logic [4:0]  in_channel = '0;
  logic [11:0] in_data = '0;
  logic        in_startofpacket = 1'b0, in_endofpacket = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [4:0]  out_channel;
  logic [11:0] out_data;
  logic        overflow;

  adc_channel_averager #(.NUM_CH(NUM_CH), .LOG2_AVG(L), .OFIFO_DEPTH(DEPTH)) dut (
    .clk_clk          (clk_clk),
    .reset_reset_n    (reset_reset_n),
    .enable           (enable),
    .clear            (clear),
    .in_valid         (in_valid),
    .in_channel       (in_channel),
    .in_data          (in_data),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_channel      (out_channel),
    .out_data         (out_data),
    .overflow         (overflow)
  );

  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: running window sums per channel, results as {ch,avg} in a bounded queue.
  int m_sum [NUM_CH];
  int m_n   [NUM_CH];
  int m_q[$];
  int m_last;
  bit m_ovf;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_sum[i] = 0;
      m_n[i]   = 0;
    end
    m_q.delete();
    m_last = 0;
    m_ovf  = 0;
  endfunction

  function automatic void model_cycle(bit v, int ch, int d, bit rdy, bit en, bit clr);
    bit pop, have;
    int res;
    if (clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_sum[i] = 0;
        m_n[i]   = 0;
      end
      m_q.delete();
      m_ovf = 0;
      return;
    end
    pop  = (m_q.size() > 0) && rdy;
    have = 0;
    res  = 0;
    if (v && en && ch < NUM_CH) begin
      m_sum[ch] += d;
      m_n[ch]++;
      if (m_n[ch] == WIN) begin
        res = (ch << 12) | ((m_sum[ch] / WIN) & 'hFFF);
        have = 1;
        m_sum[ch] = 0;
        m_n[ch]   = 0;
      end
    end
    if (pop) m_last = m_q.pop_front();
    if (have) begin
      if (m_q.size() < DEPTH) m_q.push_back(res);
      else m_ovf = 1;
    end
  endfunction

  task automatic compare_outputs();
    int exp;
    exp = (m_q.size() > 0) ? m_q[0] : m_last;
    check_eq("out_valid", out_valid, (m_q.size() > 0));
    check_eq("out_channel", out_channel, exp >> 12);
    check_eq("out_data", out_data, exp & 'hFFF);
    check_eq("overflow", overflow, m_ovf);
  endtask

  task automatic step(input bit v, input int ch, input int d, input bit rdy, input bit en, input bit clr);
    in_valid   = v;
    in_channel = 5'(ch);
    in_data    = 12'(d);
    out_ready  = rdy;
    enable     = en;
    clear      = clr;
    in_startofpacket = v & ($urandom % 2 == 0);
    in_endofpacket   = v & ($urandom % 2 == 0);
    model_cycle(v, ch, d, rdy, en, clr);
    @(posedge clk_clk);
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 1, 0);
  endtask

  int rdy_pct;

  initial begin
    model_reset();
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_channel", out_channel, 0);
    check_eq("rst_overflow", overflow, 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    idle(2, 1);

    // 16 samples of 100 on ch1
    for (int i = 0; i < WIN; i++) step(1, 1, 100, 1, 1, 0);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_channel", out_channel, 1);
    check_eq("t1_data", out_data, 'h064);
    idle(3, 1);

    // ch0 full-scale interleaved with ch3 alternating 0/1
    for (int i = 0; i < WIN; i++) begin
      step(1, 0, 'hFFF, 1, 1, 0);
      if (i == WIN - 1) begin
        check_eq("t2_ch0_channel", out_channel, 0);
        check_eq("t2_ch0_data", out_data, 'hFFF);
      end
      step(1, 3, i & 1, 1, 1, 0);
    end
    check_eq("t2_ch3_channel", out_channel, 3);
    check_eq("t2_ch3_data", out_data, 0);
    idle(3, 1);

    // five windows with the sink stalled: one result dropped
    step(0, 0, 0, 0, 1, 1);
    for (int w = 0; w < 5; w++)
      for (int k = 0; k < WIN; k++) step(1, 2, $urandom_range(0, 4095), 0, 1, 0);
    check_eq("t3_overflow", overflow, 1);
    check_eq("t3_valid", out_valid, 1);
    idle(6, 1);
    check_eq("t3_drained", out_valid, 0);

    // out-of-range channel ignored
    step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 2 * WIN; i++) step(1, 9, $urandom_range(0, 4095), 1, 1, 0);
    check_eq("t4_no_valid", out_valid, 0);
    check_eq("t4_no_ovf", overflow, 0);
    for (int i = 0; i < WIN; i++) step(1, 7, $urandom_range(0, 4095), 1, 1, 0);
    check_eq("t4_channel", out_channel, 7);
    check_eq("t4_valid", out_valid, 1);
    idle(2, 1);

    // clear mid-window discards the partial sum and the coincident sample
    for (int i = 0; i < 10; i++) step(1, 4, $urandom_range(0, 4095), 1, 1, 0);
    step(1, 4, 123, 1, 1, 1);
    for (int i = 0; i < WIN; i++) step(1, 4, 50, 1, 1, 0);
    check_eq("t5_channel", out_channel, 4);
    check_eq("t5_data", out_data, 50);
    check_eq("t5_ovf", overflow, 0);

    // async reset mid-window
    for (int i = 0; i < 10; i++) step(1, 5, $urandom_range(0, 4095), 1, 1, 0);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_data", out_data, 0);
    check_eq("t6_rst_channel", out_channel, 0);
    check_eq("t6_rst_ovf", overflow, 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    for (int i = 0; i < WIN; i++) step(1, 5, 7, 1, 1, 0);
    check_eq("t6_channel", out_channel, 5);
    check_eq("t6_data", out_data, 7);
    idle(2, 1);

    // randomized traffic with varying sink throughput
    rdy_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) rdy_pct = ($urandom % 3 == 0) ? 5 : (($urandom % 2 == 0) ? 50 : 95);
      step(($urandom % 4) != 0,
           $urandom_range(0, NUM_CH + 1),
           (($urandom % 4) == 0) ? 'hFFF : $urandom_range(0, 4095),
           ($urandom % 100) < rdy_pct,
           ($urandom % 8) != 0,
           ($urandom % 150) == 0);
    end
    idle(8, 1);
    check_eq("final_empty", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
